// File: rtl/sparse_pkg.sv
// Shared types, sizing and saturation helper for the sparse MAC datapath.
package sparse_pkg;
    localparam int IL     = 4;
    localparam int FL     = 16;
    localparam int LANES  = 16;
    localparam int N_MUL  = 4;
    localparam int GUARD  = 8;
    localparam int FX_W   = IL + FL;
    localparam int ACC_W  = IL + FL + GUARD;
    localparam int CNT_W  = $clog2(LANES) + 1;
    localparam int GROUPS = LANES / N_MUL;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LOG_N  = $clog2(N_MUL);

    typedef logic signed [FX_W-1:0]  fx_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MAC  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam fx_t FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FX_W-1){1'b0}}};

    // Clamp the wide accumulator into the operand format.
    function automatic fx_t sat_acc_to_fx(input acc_t a);
        fx_t r;
        if (a > acc_t'(FX_MAX))
            r = FX_MAX;
        else if (a < acc_t'(FX_MIN))
            r = FX_MIN;
        else
            r = a[FX_W-1:0];
        return r;
    endfunction
endpackage

// File: rtl/sparse_mac_group.sv
// One group of N_MUL fixed-point multipliers, floor-shifted by FL and summed.
module mac_group
    import sparse_pkg::*;
(
    input  logic [N_MUL*FX_W-1:0]   a_grp,
    input  logic [N_MUL*FX_W-1:0]   b_grp,
    input  logic [N_MUL-1:0]        lane_valid,
    output logic signed [ACC_W-1:0] group_sum
);
    localparam int PROD_W = 2 * FX_W;

    logic signed [PROD_W-1:0] prod [N_MUL];
    logic signed [PROD_W-1:0] shifted [N_MUL];

    // Shifted products fit well inside ACC_W, so truncation keeps the value.
    always_comb begin
        group_sum = '0;
        for (int j = 0; j < N_MUL; j++) begin
            prod[j]    = fx_t'(a_grp[j*FX_W +: FX_W]) * fx_t'(b_grp[j*FX_W +: FX_W]);
            shifted[j] = prod[j] >>> FL;
            if (lane_valid[j])
                group_sum = group_sum + ACC_W'(shifted[j]);
        end
    end
endmodule

// File: rtl/sparse_mac.sv
// Captures filtered input/weight chunks, accumulates products with saturation
// and hands one saturated dot product downstream per last-flagged chunk.
module sparse_mac
    import sparse_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES*FX_W-1:0] oi_bus,
    input  logic [LANES*FX_W-1:0] ow_bus,
    input  logic                  in_valid,
    input  logic [CNT_W-1:0]      in_count,
    input  logic                  in_last,
    output logic                  output_taken,
    output logic [FX_W-1:0]       result,
    output logic                  result_valid,
    input  logic                  result_taken,
    output logic [1:0]            state
);
    state_t cur_state, next_state;

    logic [GROUPS-1:0][N_MUL*FX_W-1:0] oi_q, ow_q;
    logic [CNT_W-1:0]         count_q;
    logic                     last_q;
    logic [GRP_W-1:0]         grp_idx;
    acc_t                     acc;
    acc_t                     acc_next;
    logic signed [ACC_W-1:0]  group_sum;
    logic signed [ACC_W:0]    acc_wide;
    logic [CNT_W:0]           lane_base;
    logic [N_MUL-1:0]         lane_valid;
    logic                     final_group;
    logic                     capture;

    assign state = cur_state;

    mac_group u_group (
        .a_grp      (oi_q[grp_idx]),
        .b_grp      (ow_q[grp_idx]),
        .lane_valid (lane_valid),
        .group_sum  (group_sum)
    );

    // Lane masking, last-group detect and saturating accumulate.
    always_comb begin
        lane_base  = (CNT_W+1)'(grp_idx) << LOG_N;
        lane_valid = '0;
        for (int j = 0; j < N_MUL; j++)
            lane_valid[j] = (lane_base + (CNT_W+1)'(j)) < {1'b0, count_q};
        final_group = (lane_base + (CNT_W+1)'(N_MUL)) >= {1'b0, count_q};
        acc_wide    = {acc[ACC_W-1], acc} + {group_sum[ACC_W-1], group_sum};
        if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
            acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_next = acc_wide[ACC_W-1:0];
    end

    always_comb begin
        next_state = cur_state;
        capture    = 1'b0;
        case (cur_state)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (in_count == '0)
                        next_state = in_last ? DONE : IDLE;
                    else
                        next_state = MAC;
                end
            end
            MAC: begin
                if (final_group)
                    next_state = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (result_taken)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result is latched on DONE entry, from the post-MAC value when coming from MAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= IDLE;
            oi_q         <= '0;
            ow_q         <= '0;
            count_q      <= '0;
            last_q       <= 1'b0;
            grp_idx      <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            output_taken <= 1'b0;
        end else begin
            cur_state    <= next_state;
            output_taken <= capture;
            if (capture) begin
                oi_q    <= oi_bus;
                ow_q    <= ow_bus;
                count_q <= in_count;
                last_q  <= in_last;
                grp_idx <= '0;
            end
            if (cur_state == MAC) begin
                acc     <= acc_next;
                grp_idx <= grp_idx + GRP_W'(1);
            end
            if (next_state == DONE && cur_state != DONE) begin
                result       <= sat_acc_to_fx((cur_state == MAC) ? acc_next : acc);
                result_valid <= 1'b1;
            end
            if (cur_state == DONE && result_taken) begin
                result_valid <= 1'b0;
                acc          <= '0;
            end
        end
    end
endmodule

// File: doc/sparse_mac.md
Name: sparse_mac

Overview:
- Downstream consumer of the sparsity filter stage.
- Takes the compacted input/weight pairs the filter emits (oi/ow lanes plus a valid-pair count) and multiplies them in Q(IL).(FL) fixed point, N_MUL lanes per cycle.
- Accumulates across successive filter chunks until a chunk flagged last arrives, then presents one saturated dot-product result to the next stage through a valid/taken handshake.

Parameters:
- IL, 4, integer bits of operands and result (sign included)
- FL, 16, fractional bits of operands, accumulator and result
- LANES, 16, pair lanes delivered per filter chunk
- N_MUL, 4, multipliers used per cycle; must divide LANES
- GUARD, 8, extra integer bits in the accumulator; ACC_W = IL+FL+GUARD

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- oi_bus  in  LANES*(IL+FL)  filtered inputs; lane k at [k*(IL+FL) +: IL+FL], signed
- ow_bus  in  LANES*(IL+FL)  filtered weights, same packing
- in_valid  in  1  filter has a chunk ready
- in_count  in  $clog2(LANES)+1  number of valid pairs, lanes 0..in_count-1; range 0..LANES
- in_last  in  1  chunk closes the current dot product
- output_taken  out  1  one-cycle pulse: chunk captured; drives the filter's output_taken
- result  out  IL+FL  saturated dot product, signed Q(IL).(FL)
- result_valid  out  1  result held stable until taken
- result_taken  in  1  downstream acknowledges result
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous, any state): state=IDLE, accumulator=0, result=0, result_valid=0, output_taken=0, capture registers and lane index cleared. A chunk in flight is discarded and no output_taken is issued for it.
- States, encoding: IDLE=00, MAC=01, DONE=10. 11 is unreachable and recovers to IDLE.
- IDLE, in_valid sampled high at edge T:
  - Latch both buses, in_count and in_last; set idx=0.
  - Go to MAC; output_taken=1 during cycle T+1 only.
  - If in_count=0: skip MAC. Go to DONE when in_last=1 (the accumulator is unchanged), otherwise stay in IDLE. output_taken still pulses.
- MAC, one group per cycle:
  - Lanes idx..idx+N_MUL-1 are processed; a lane at or beyond count contributes 0.
  - Each product is the full 2*(IL+FL)-bit signed product, arithmetic-shifted right by FL (floor, no rounding).
  - The group sum is added to the accumulator with saturation to the signed ACC_W range.
  - idx += N_MUL. When idx+N_MUL >= count, the group just processed is the final one: go to DONE if last=1, else to IDLE.
  - A chunk of count c takes ceil(c/N_MUL) MAC cycles.
- in_valid while in MAC or DONE: ignored and not captured. The filter holds its outputs until output_taken.
- Entering DONE:
  - result = accumulator saturated to IL+FL bits: max 0x7FFFF, min 0x80000 at defaults.
  - result_valid=1 from the first DONE cycle; result is stable while in DONE.
- DONE, result_taken high at an edge: result_valid=0, accumulator=0, go to IDLE. A new chunk can be captured on the next edge.
- result_taken outside DONE: no effect.
- Latency at defaults: in_valid at edge T with count=c and last=1 gives result_valid at cycle T+1+ceil(c/4).

Decomposition:
- Shared package sparse_pkg holds:
  - fixed-point typedef fx_t, logic signed [IL+FL-1:0]
  - acc_t, ACC_W wide
  - state enum state_t {IDLE, MAC, DONE}
  - saturation function sat_acc_to_fx
- One sub-module: mac_group. Purely combinational; N_MUL multipliers, shift and adder tree. Inputs are the operand slices and a lane-valid mask; output is the group sum.
- The FSM, capture registers and saturating accumulator stay in sparse_mac.

Test Plan:
- Single chunk: count=2, pairs (1.0,2.0)=(0x10000,0x20000) and (0.5,-1.0)=(0x08000,0xF0000), last=1 -> output_taken at T+1, result_valid at T+2, result=0x18000 (1.5); result_taken -> result_valid=0, back to IDLE.
- Full chunk timing: count=16, all pairs (1.0,1.0), last=1 -> exactly 4 MAC cycles, result_valid at T+5, result=0x7FFFF (16.0 saturates the output).
- Multi-chunk with accumulator saturation:
  - Three chunks, each 16 pairs of (7.0,7.0); first two last=0, third last=1.
  - Each chunk adds 784.0; the accumulator clamps at 2047.99 and the third chunk's addition does not wrap.
  - result=0x7FFFF. Negative mirror with (-8.0,7.0) gives result=0x80000.
- Zero-count chunk: count=0, last=1, after a prior chunk summing to 0x0C000 -> no MAC cycle, output_taken pulses, result=0x0C000.
- Backpressure: hold result_taken=0 for 10 cycles with in_valid=1 -> result stable, no further output_taken pulses. Releasing result_taken captures the pending chunk on the following edge.
- Reset mid-MAC: assert reset during the second MAC cycle of a 16-pair chunk -> all outputs 0 immediately, state=00. The next chunk accumulates from 0.
